// File: rtl/servant_vpu_mem_arbiter.sv
// Single-port RAM arbiter between the servant CPU Wishbone stream and the VPU word port.
// Three-cycle access (IDLE/ISSUE/ACK) with bounded VPU priority under contention.
module servant_vpu_mem_arbiter #(
  parameter int aw            = 13,
  parameter int MAX_VPU_BURST = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [31:0]   i_wb_cpu_adr,
  input  logic [31:0]   i_wb_cpu_dat,
  input  logic [3:0]    i_wb_cpu_sel,
  input  logic          i_wb_cpu_we,
  input  logic          i_wb_cpu_cyc,
  output logic [31:0]   o_wb_cpu_rdt,
  output logic          o_wb_cpu_ack,
  input  logic          i_vpu_request_rd,
  input  logic          i_vpu_request_wr,
  input  logic [aw-1:0] i_vpu_adr,
  input  logic [31:0]   i_vpu_dat,
  input  logic [3:0]    i_vpu_sel,
  output logic [31:0]   o_vpu_rdt,
  output logic          o_vpu_ack,
  output logic [aw-3:0] o_mem_adr,
  output logic [31:0]   o_mem_dat,
  output logic [3:0]    o_mem_sel,
  output logic          o_mem_we,
  output logic          o_mem_en,
  input  logic [31:0]   i_mem_rdt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_ACK
  } state_t;

  localparam logic [3:0] LP_MAX_BURST = 4'(MAX_VPU_BURST);

  state_t        r_state;
  state_t        w_next;
  logic          r_own;
  logic [3:0]    r_vrun;
  logic [aw-3:0] r_mem_adr;
  logic [31:0]   r_mem_dat;
  logic [3:0]    r_mem_sel;
  logic          r_mem_we;

  logic          w_cpu_req;
  logic          w_vpu_req;
  logic          w_grant_cpu;
  logic          w_grant_vpu;
  logic          w_unused;

  assign w_cpu_req = i_wb_cpu_cyc;
  assign w_vpu_req = i_vpu_request_rd | i_vpu_request_wr;
  assign w_unused  = ^{i_wb_cpu_adr[31:aw], i_wb_cpu_adr[1:0], i_vpu_adr[1:0]};

  always_comb begin
    w_next      = r_state;
    w_grant_cpu = 1'b0;
    w_grant_vpu = 1'b0;
    case (r_state)
      S_IDLE: begin
        // VPU wins ties only until it has used up its burst allowance
        if (w_vpu_req && (!w_cpu_req || (r_vrun < LP_MAX_BURST))) begin
          w_grant_vpu = 1'b1;
          w_next      = S_ISSUE;
        end else if (w_cpu_req) begin
          w_grant_cpu = 1'b1;
          w_next      = S_ISSUE;
        end
      end
      S_ISSUE: w_next = S_ACK;
      S_ACK:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_own     <= 1'b0;
      r_vrun    <= '0;
      r_mem_adr <= '0;
      r_mem_dat <= '0;
      r_mem_sel <= '0;
      r_mem_we  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_grant_vpu) begin
        r_own     <= 1'b1;
        r_mem_adr <= i_vpu_adr[aw-1:2];
        r_mem_dat <= i_vpu_dat;
        r_mem_we  <= i_vpu_request_wr;
        r_mem_sel <= i_vpu_request_wr ? i_vpu_sel : 4'h0;
        r_vrun    <= (r_vrun == 4'hF) ? 4'hF : r_vrun + 4'd1;
      end else if (w_grant_cpu) begin
        r_own     <= 1'b0;
        r_mem_adr <= i_wb_cpu_adr[aw-1:2];
        r_mem_dat <= i_wb_cpu_dat;
        r_mem_we  <= i_wb_cpu_we;
        r_mem_sel <= i_wb_cpu_sel;
        r_vrun    <= '0;
      end else if ((r_state == S_IDLE) && !w_vpu_req) begin
        r_vrun <= '0;
      end
    end
  end

  // Address/data/sel stay registered; only the strobes are gated to ISSUE
  assign o_mem_adr    = r_mem_adr;
  assign o_mem_dat    = r_mem_dat;
  assign o_mem_sel    = r_mem_sel;
  assign o_mem_en     = (r_state == S_ISSUE);
  assign o_mem_we     = r_mem_we & (r_state == S_ISSUE);

  assign o_wb_cpu_ack = (r_state == S_ACK) & ~r_own;
  assign o_vpu_ack    = (r_state == S_ACK) & r_own;
  assign o_wb_cpu_rdt = i_mem_rdt;
  assign o_vpu_rdt    = i_mem_rdt;

endmodule

// File: tb/tb_servant_vpu_mem_arbiter.sv
// Scoreboard bench for servant_vpu_mem_arbiter: drivers push expected accesses,
// a negedge monitor checks the RAM port and acks against them.
module tb_servant_vpu_mem_arbiter;

  localparam int AW = 13;

  logic          clk = 1'b0;
  logic          i_rst;
  logic [31:0]   i_wb_cpu_adr;
  logic [31:0]   i_wb_cpu_dat;
  logic [3:0]    i_wb_cpu_sel;
  logic          i_wb_cpu_we;
  logic          i_wb_cpu_cyc;
  logic [31:0]   o_wb_cpu_rdt;
  logic          o_wb_cpu_ack;
  logic          i_vpu_request_rd;
  logic          i_vpu_request_wr;
  logic [AW-1:0] i_vpu_adr;
  logic [31:0]   i_vpu_dat;
  logic [3:0]    i_vpu_sel;
  logic [31:0]   o_vpu_rdt;
  logic          o_vpu_ack;
  logic [AW-3:0] o_mem_adr;
  logic [31:0]   o_mem_dat;
  logic [3:0]    o_mem_sel;
  logic          o_mem_we;
  logic          o_mem_en;
  logic [31:0]   i_mem_rdt;

  always #5 clk = ~clk;

  servant_vpu_mem_arbiter #(
    .aw            (AW),
    .MAX_VPU_BURST (4)
  ) dut (
    .i_clk            (clk),
    .i_rst            (i_rst),
    .i_wb_cpu_adr     (i_wb_cpu_adr),
    .i_wb_cpu_dat     (i_wb_cpu_dat),
    .i_wb_cpu_sel     (i_wb_cpu_sel),
    .i_wb_cpu_we      (i_wb_cpu_we),
    .i_wb_cpu_cyc     (i_wb_cpu_cyc),
    .o_wb_cpu_rdt     (o_wb_cpu_rdt),
    .o_wb_cpu_ack     (o_wb_cpu_ack),
    .i_vpu_request_rd (i_vpu_request_rd),
    .i_vpu_request_wr (i_vpu_request_wr),
    .i_vpu_adr        (i_vpu_adr),
    .i_vpu_dat        (i_vpu_dat),
    .i_vpu_sel        (i_vpu_sel),
    .o_vpu_rdt        (o_vpu_rdt),
    .o_vpu_ack        (o_vpu_ack),
    .o_mem_adr        (o_mem_adr),
    .o_mem_dat        (o_mem_dat),
    .o_mem_sel        (o_mem_sel),
    .o_mem_we         (o_mem_we),
    .o_mem_en         (o_mem_en),
    .i_mem_rdt        (i_mem_rdt)
  );

  // RAM model: byte-enabled write, registered read
  logic [31:0] ram [0:2047];
  logic        preload;
  int          wr18 = 0;

  always @(posedge clk) begin
    if (o_mem_en) begin
      if (o_mem_we) begin
        for (int b = 0; b < 4; b++)
          if (o_mem_sel[b]) ram[o_mem_adr][8*b +: 8] <= o_mem_dat[8*b +: 8];
        if (o_mem_adr == 11'd18) wr18 <= wr18 + 1;
      end
      i_mem_rdt <= ram[o_mem_adr];
    end
    if (preload) begin
      ram[0]  <= 32'h0BAD_F00D;
      ram[5]  <= 32'hDEAD_BEEF;
      ram[16] <= 32'hFFFF_FFFF;
      ram[17] <= 32'h0000_0000;
      ram[18] <= 32'h0000_0000;
    end
  end

  typedef struct {
    logic [10:0] adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wdat;
    logic        chk;
    logic [31:0] rdt;
  } exp_t;

  exp_t cpu_q[$];
  exp_t vpu_q[$];
  bit   ord_q[$];  // expected grant order, 1 = VPU
  bit   mem_chk_off = 1'b0;
  int   ack_cnt = 0;
  int   n_pass = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic exp_t mk(input logic [10:0] adr, input logic we, input logic [3:0] sel,
                              input logic [31:0] wdat, input logic chk, input logic [31:0] rdt);
    exp_t e;
    e.adr = adr; e.we = we; e.sel = sel; e.wdat = wdat; e.chk = chk; e.rdt = rdt;
    return e;
  endfunction

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    bit   own;
    if (!i_rst) begin
      if (o_mem_en && !mem_chk_off) begin
        if (ord_q.size() == 0 || (ord_q[0] ? vpu_q.size() : cpu_q.size()) == 0) begin
          check("unexpected_mem_en", {31'b0, o_mem_en}, 32'd0);
        end else begin
          e = ord_q[0] ? vpu_q[0] : cpu_q[0];
          check("mem_adr", 32'(o_mem_adr), 32'(e.adr));
          check("mem_we",  32'(o_mem_we),  32'(e.we));
          check("mem_sel", 32'(o_mem_sel), 32'(e.sel));
          if (e.we) check("mem_dat", o_mem_dat, e.wdat);
        end
      end
      if (o_wb_cpu_ack || o_vpu_ack) begin
        ack_cnt++;
        check("ack_mem_en_low", {31'b0, o_mem_en}, 32'd0);
        if (ord_q.size() == 0) begin
          check("unexpected_ack", {30'b0, o_wb_cpu_ack, o_vpu_ack}, 32'd0);
        end else begin
          own = ord_q.pop_front();
          check("ack_owner", {30'b0, o_wb_cpu_ack, o_vpu_ack}, own ? 32'd1 : 32'd2);
          if (own && vpu_q.size() > 0) begin
            e = vpu_q.pop_front();
            if (e.chk) check("vpu_rdt", o_vpu_rdt, e.rdt);
          end else if (!own && cpu_q.size() > 0) begin
            e = cpu_q.pop_front();
            if (e.chk) check("cpu_rdt", o_wb_cpu_rdt, e.rdt);
          end
        end
      end
    end
  end

  // Drivers: called at posedge+1, return at posedge+1 of the cycle after the ack
  task automatic cpu_access(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                            input logic we, output int lat);
    i_wb_cpu_cyc = 1'b1; i_wb_cpu_adr = adr; i_wb_cpu_dat = dat;
    i_wb_cpu_sel = sel;  i_wb_cpu_we  = we;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!o_wb_cpu_ack && lat < 100);
    if (!o_wb_cpu_ack) check("cpu_ack_timeout", {31'b0, o_wb_cpu_ack}, 32'd1);
    @(posedge clk); #1;
    i_wb_cpu_cyc = 1'b0;
  endtask

  task automatic vpu_access(input logic rd, input logic wr, input logic [AW-1:0] adr,
                            input logic [31:0] dat, input logic [3:0] sel, output int lat);
    i_vpu_request_rd = rd; i_vpu_request_wr = wr; i_vpu_adr = adr;
    i_vpu_dat = dat; i_vpu_sel = sel;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!o_vpu_ack && lat < 100);
    if (!o_vpu_ack) check("vpu_ack_timeout", {31'b0, o_vpu_ack}, 32'd1);
    @(posedge clk); #1;
    i_vpu_request_rd = 1'b0; i_vpu_request_wr = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_mem_adr"}, 32'(o_mem_adr), 32'd0);
    check({tag, "_mem_dat"}, o_mem_dat, 32'd0);
    check({tag, "_mem_sel"}, 32'(o_mem_sel), 32'd0);
    check({tag, "_mem_we"},  32'(o_mem_we), 32'd0);
    check({tag, "_mem_en"},  32'(o_mem_en), 32'd0);
    check({tag, "_acks"},    {30'b0, o_wb_cpu_ack, o_vpu_ack}, 32'd0);
  endtask

  int lat_c, lat_v, ack_snap;

  initial begin
    i_rst = 1'b1; preload = 1'b1;
    i_wb_cpu_adr = '0; i_wb_cpu_dat = '0; i_wb_cpu_sel = '0; i_wb_cpu_we = 1'b0; i_wb_cpu_cyc = 1'b0;
    i_vpu_request_rd = 1'b0; i_vpu_request_wr = 1'b0; i_vpu_adr = '0; i_vpu_dat = '0; i_vpu_sel = '0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    i_rst = 1'b0; preload = 1'b0;
    @(posedge clk); #1;

    // CPU read alone
    cpu_q.push_back(mk(11'd5, 1'b0, 4'hF, 32'h0, 1'b1, 32'hDEAD_BEEF)); ord_q.push_back(1'b0);
    cpu_access(32'h14, 32'h0, 4'hF, 1'b0, lat_c);
    check("cpu_read_latency", lat_c, 32'd2);

    // VPU partial write then read back
    vpu_q.push_back(mk(11'd16, 1'b1, 4'b0011, 32'h1234_5678, 1'b0, 32'h0)); ord_q.push_back(1'b1);
    vpu_access(1'b0, 1'b1, 13'h40, 32'h1234_5678, 4'b0011, lat_v);
    check("vpu_write_latency", lat_v, 32'd2);
    vpu_q.push_back(mk(11'd16, 1'b0, 4'h0, 32'h0, 1'b1, 32'hFFFF_5678)); ord_q.push_back(1'b1);
    vpu_access(1'b1, 1'b0, 13'h40, 32'h0, 4'hF, lat_v);

    // Illegal rd+wr behaves as a write
    vpu_q.push_back(mk(11'd17, 1'b1, 4'b1100, 32'hA5A5_A5A5, 1'b0, 32'h0)); ord_q.push_back(1'b1);
    vpu_access(1'b1, 1'b1, 13'h44, 32'hA5A5_A5A5, 4'b1100, lat_v);
    cpu_q.push_back(mk(11'd17, 1'b0, 4'hF, 32'h0, 1'b1, 32'hA5A5_0000)); ord_q.push_back(1'b0);
    cpu_access(32'h44, 32'h0, 4'hF, 1'b0, lat_c);

    // Address wrap: 0x2000 hits word 0
    cpu_q.push_back(mk(11'd0, 1'b0, 4'hF, 32'h0, 1'b1, 32'h0BAD_F00D)); ord_q.push_back(1'b0);
    cpu_access(32'h2000, 32'h0, 4'hF, 1'b0, lat_c);

    // Contention: V,V,V,V,C,V,V,V,V,C
    for (int i = 0; i < 8; i++)
      vpu_q.push_back(mk(11'(32 + i), 1'b1, 4'hF, 32'(i), 1'b0, 32'h0));
    cpu_q.push_back(mk(11'd5,  1'b0, 4'hF, 32'h0, 1'b1, 32'hDEAD_BEEF));
    cpu_q.push_back(mk(11'd16, 1'b0, 4'hF, 32'h0, 1'b1, 32'hFFFF_5678));
    for (int k = 0; k < 10; k++) ord_q.push_back(!(k == 4 || k == 9));
    fork
      begin
        int lv;
        for (int i = 0; i < 8; i++) vpu_access(1'b0, 1'b1, 13'(32'h80 + 4 * i), 32'(i), 4'hF, lv);
      end
      begin
        cpu_access(32'h14, 32'h0, 4'hF, 1'b0, lat_c);
        check("contention_cpu_wait0", lat_c, 32'd14);
        cpu_access(32'h40, 32'h0, 4'hF, 1'b0, lat_c);
        check("contention_cpu_wait1", lat_c, 32'd14);
      end
    join

    // Burst counter clears after an idle VPU cycle
    for (int i = 0; i < 3; i++) begin
      vpu_q.push_back(mk(11'(32 + i), 1'b0, 4'h0, 32'h0, 1'b1, 32'(i)));
      ord_q.push_back(1'b1);
    end
    for (int i = 0; i < 3; i++) vpu_access(1'b1, 1'b0, 13'(32'h80 + 4 * i), 32'h0, 4'hF, lat_v);
    @(posedge clk); #1;
    for (int i = 3; i < 8; i++)
      vpu_q.push_back(mk(11'(32 + i), 1'b0, 4'h0, 32'h0, 1'b1, 32'(i)));
    cpu_q.push_back(mk(11'd0, 1'b0, 4'hF, 32'h0, 1'b1, 32'h0BAD_F00D));
    for (int k = 0; k < 6; k++) ord_q.push_back(k != 4);
    fork
      begin
        int lv;
        for (int i = 3; i < 8; i++) vpu_access(1'b1, 1'b0, 13'(32'h80 + 4 * i), 32'h0, 4'hF, lv);
      end
      begin
        cpu_access(32'h0, 32'h0, 4'hF, 1'b0, lat_c);
        check("idle_reset_cpu_wait", lat_c, 32'd14);
      end
    join

    // Reset during ISSUE of a CPU write aborts it
    mem_chk_off = 1'b1;
    ack_snap = ack_cnt;
    i_wb_cpu_cyc = 1'b1; i_wb_cpu_adr = 32'h48; i_wb_cpu_dat = 32'h1111_1111;
    i_wb_cpu_sel = 4'hF; i_wb_cpu_we = 1'b1;
    @(posedge clk); #1;
    check("abort_issue_en", 32'(o_mem_en), 32'd1);
    check("abort_issue_adr", 32'(o_mem_adr), 32'd18);
    i_rst = 1'b1; i_wb_cpu_cyc = 1'b0; i_wb_cpu_we = 1'b0;
    @(posedge clk); #1;
    check_outputs_zero("abort");
    i_rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("abort_no_ack", ack_cnt, ack_snap);
    check("abort_ram_writes_le1", {31'b0, (wr18 <= 1)}, 32'd1);
    mem_chk_off = 1'b0;

    // Normal service resumes after the abort
    cpu_q.push_back(mk(11'd18, 1'b0, 4'hF, 32'h0, 1'b0, 32'h0)); ord_q.push_back(1'b0);
    cpu_access(32'h48, 32'h0, 4'hF, 1'b0, lat_c);
    check("post_abort_latency", lat_c, 32'd2);

    repeat (3) @(posedge clk);
    #1;
    check("ord_q_drained", ord_q.size(), 32'd0);
    check("cpu_q_drained", cpu_q.size(), 32'd0);
    check("vpu_q_drained", vpu_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
